parc_core_scoreboard_multi: RTL and testbench
=============================================

Name: parc_core_scoreboard_multi

Overview:
Parametrised successor to the 5-stage PARC scoreboard. Tracks pending destination registers, remaining writeback latency, producing functional unit, ROB slot and speculative status. Generates the decode-stage stall, per-source bypass selects, ROB bypass slots and writeback mux select. Adds a configurable register count, FU count and latency depth, register-0 suppression, and squash of speculative entries on mispredict.

Parameters:
NUM_REGS, 32, architectural registers; index width RW = clog2(NUM_REGS)
NUM_FU, 3, functional units, encoded 1..NUM_FU (0 = none)
LAT_W, 6, width of one-hot latency vectors and stall mask
BYP_LAT, 2, source is bypassable when its latency bit index < BYP_LAT
ROB_W, 4, ROB slot index width
SEL_W, 3, bypass-select width; must hold NUM_FU+2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
src0 / src1  in  RW  source register indices
src0_en / src1_en  in  1  source is read
dst  in  RW  non-spec destination
dst_en  in  1  non-spec instruction writes dst
func_unit  in  clog2(NUM_FU+1)  FU of the non-spec instruction
latency  in  LAT_W  one-hot writeback latency
inst_val_Dhl  in  1  decode instruction valid
non_sb_stall_Dhl  in  1  stall from outside the scoreboard
spec_Dhl  in  1  decode instruction is speculative (it is not accepted through the non-spec port)
dst_spec, func_unit_spec, latency_spec  in  as above  speculative-issue destination
spec_accept_Ihl  in  1  speculative instruction issued this cycle
rob_alloc_slot, rob_alloc_slot_spec  in  ROB_W  slots allocated to dst / dst_spec
rob_commit_slot  in  ROB_W  slot committed
rob_commit_wen  in  1  commit valid
spec_resolve  in  1  speculation confirmed; clear all spec marks
spec_squash  in  1  mispredict; drop all spec entries
stalls  in  LAT_W  per-stage hold mask
src0_byp_mux_sel / src1_byp_mux_sel  out  SEL_W  bypass select
src0_byp_rob_slot / src1_byp_rob_slot  out  ROB_W  ROB slot of the source producer
stall_hazard  out  1  decode must stall
wb_mux_sel  out  clog2(NUM_FU+1)  writeback FU select

Behaviour:
- State per register r: pending, spec, fu, lat[LAT_W], rob. Per FU f: wb_lat[f][LAT_W].
- Reset (1 cycle): all pending, spec, lat, fu and wb_lat cleared. The rob array is not reset.
- Reset outputs: byp sels 0, stall_hazard = !(inst_val_Dhl && !non_sb_stall_Dhl) evaluated on the cleared state, wb_mux_sel 0.
- Register 0 is never marked pending. Writes to index 0 are ignored by both issue ports.
- Source ready: src_ok = !src_en || !pending || lat bit index < BYP_LAT.
- Same-cycle spec conflict: if spec_accept_Ihl is high and src == dst_spec (nonzero), src_ok = 0.
- Writeback structural hazard: wb_hz = ((OR over f of wb_lat[f] >> 1) | (spec_accept_Ihl ? latency_spec : 0)) & latency != 0.
- accept = src0_ok && src1_ok && !wb_hz && inst_val_Dhl && !non_sb_stall_Dhl && !spec_Dhl && dst_en.
- stall_hazard = !(src0_ok && src1_ok && !wb_hz && inst_val_Dhl && !non_sb_stall_Dhl).
- Register update priority (highest first):
  1. reset
  2. accept to r: load latency/func_unit/rob_alloc_slot, pending=1, spec=0
  3. spec_accept_Ihl to r: load the spec fields, pending=1, spec=1
  4. spec_squash && spec[r]: pending=0, spec=0, lat=0
  5. otherwise: lat <= (lat & stalls) | ((lat & ~stalls) >> 1); pending cleared when rob_commit_wen and rob_commit_slot == rob[r]; spec cleared on spec_resolve
- If accept and spec_accept_Ihl target the same dst, accept wins, including the rob field.
- wb_lat[f] <= shift-with-hold as above | latency if accept to f | latency_spec if spec accept to f. spec_squash does not clear wb_lat; it stays conservative until drained.
- Bypass select, combinational:
  - 0 if !pending or src == 0
  - NUM_FU+1 if lat == 1 (writeback stage)
  - NUM_FU+2 if lat == 0 (value in ROB)
  - otherwise fu
- src_byp_rob_slot = rob[src] (combinational).
- wb_mux_sel = lowest f with wb_lat[f][1] set, else 0.
- spec_resolve and spec_squash asserted together: squash wins.

Optional Feature:
SCOREBOARD_WAW_CHECK_EN
- Defined: accept additionally requires !(pending[dst] && lat[dst] > latency), and stall_hazard includes the same term, so writebacks stay in order.
- Undefined: no WAW check; a later write simply overwrites the entry.

Test Plan:
- Reset, then src0=3, src0_en=1 with r3 idle -> src0_byp_mux_sel=0, stall_hazard=0.
- Accept dst=5, FU=3, latency=6'b001000; next cycle src0=5 -> stall=1, sel=3. After 2 unstalled cycles: lat=6'b000010, stall=0, sel=3. Next cycle: lat=1, sel=NUM_FU+1=4. Following cycle: sel=5, src0_byp_rob_slot = allocated slot.
- Accept dst=0, latency=6'b000100 -> pending[0] stays 0; a later src0=0 gives sel 0, no stall.
- Spec accept dst=7 (latency 6'b000100); same cycle a decode reading r7 -> stall_hazard=1. Then spec_squash -> pending[7]=0, next read of r7 gives sel 0.
- Pending wb_alu_lat=6'b000100; new accept with latency=6'b000010 -> stall_hazard=1 (wb conflict); with latency 6'b000100 -> no stall.
- Commit matching rob[9] while pending[9] -> pending cleared next cycle. Commit and a new accept to r9 in the same cycle -> r9 stays pending with the new slot.

Source files
------------

// File: rtl/parc_core_scoreboard_multi.sv
// rtl/parc_core_scoreboard_multi.sv - parametrised PARC scoreboard with ROB bypass and speculative squash
// Optional feature macro: SCOREBOARD_WAW_CHECK_EN (in-order writeback check against the pending entry of dst)
module parc_core_scoreboard_multi #(
    parameter int NUM_REGS = 32,
    parameter int NUM_FU   = 3,
    parameter int LAT_W    = 6,
    parameter int BYP_LAT  = 2,
    parameter int ROB_W    = 4,
    parameter int SEL_W    = 3,
    localparam int RW      = $clog2(NUM_REGS),
    localparam int FW      = $clog2(NUM_FU + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    src0,
    input  logic             src0_en,
    input  logic [RW-1:0]    src1,
    input  logic             src1_en,
    input  logic [RW-1:0]    dst,
    input  logic             dst_en,
    input  logic [FW-1:0]    func_unit,
    input  logic [LAT_W-1:0] latency,
    input  logic             inst_val_Dhl,
    input  logic             non_sb_stall_Dhl,
    input  logic             spec_Dhl,
    input  logic [RW-1:0]    dst_spec,
    input  logic [FW-1:0]    func_unit_spec,
    input  logic [LAT_W-1:0] latency_spec,
    input  logic             spec_accept_Ihl,
    input  logic [ROB_W-1:0] rob_alloc_slot,
    input  logic [ROB_W-1:0] rob_alloc_slot_spec,
    input  logic [ROB_W-1:0] rob_commit_slot,
    input  logic             rob_commit_wen,
    input  logic             spec_resolve,
    input  logic             spec_squash,
    input  logic [LAT_W-1:0] stalls,
    output logic [SEL_W-1:0] src0_byp_mux_sel,
    output logic [SEL_W-1:0] src1_byp_mux_sel,
    output logic [ROB_W-1:0] src0_byp_rob_slot,
    output logic [ROB_W-1:0] src1_byp_rob_slot,
    output logic             stall_hazard,
    output logic [FW-1:0]    wb_mux_sel
);

    // Latency bits at or above BYP_LAT are too far from writeback to bypass.
    localparam logic [LAT_W-1:0] SLOW_MASK = ~LAT_W'((1 << BYP_LAT) - 1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] spec_mark;
    logic [FW-1:0]       fu     [NUM_REGS];
    logic [LAT_W-1:0]    lat    [NUM_REGS];
    logic [ROB_W-1:0]    rob    [NUM_REGS];
    logic [LAT_W-1:0]    wb_lat [1:NUM_FU];

    logic             src0_ok, src1_ok;
    logic             wb_hz, waw_hz, accept;
    logic [LAT_W-1:0] wb_or;

    function automatic logic [SEL_W-1:0] byp_sel(input logic [RW-1:0] s, input logic p,
                                                 input logic [LAT_W-1:0] l, input logic [FW-1:0] f);
        if (!p || s == '0)          return '0;
        else if (l == LAT_W'(1))    return SEL_W'(NUM_FU + 1);
        else if (l == '0)           return SEL_W'(NUM_FU + 2);
        else                        return SEL_W'(f);
    endfunction

    // A source is blocked by a slow in-flight producer or by a speculative write issuing this cycle.
    assign src0_ok = (!src0_en || !pending[src0] || ((lat[src0] & SLOW_MASK) == '0))
                     && !(spec_accept_Ihl && dst_spec != '0 && src0 == dst_spec);
    assign src1_ok = (!src1_en || !pending[src1] || ((lat[src1] & SLOW_MASK) == '0))
                     && !(spec_accept_Ihl && dst_spec != '0 && src1 == dst_spec);

    // Union of all FU writeback slots, used to detect writeback port collisions.
    always_comb begin
        wb_or = '0;
        for (int f = 1; f <= NUM_FU; f++) wb_or = wb_or | wb_lat[f];
    end

    assign wb_hz = (((wb_or >> 1) | (spec_accept_Ihl ? latency_spec : '0)) & latency) != '0;

`ifdef SCOREBOARD_WAW_CHECK_EN
    assign waw_hz = pending[dst] && (lat[dst] > latency);
`else
    assign waw_hz = 1'b0;
`endif

    assign accept = src0_ok && src1_ok && !wb_hz && !waw_hz && inst_val_Dhl
                    && !non_sb_stall_Dhl && !spec_Dhl && dst_en;
    assign stall_hazard = !(src0_ok && src1_ok && !wb_hz && !waw_hz && inst_val_Dhl && !non_sb_stall_Dhl);

    assign src0_byp_mux_sel  = byp_sel(src0, pending[src0], lat[src0], fu[src0]);
    assign src1_byp_mux_sel  = byp_sel(src1, pending[src1], lat[src1], fu[src1]);
    assign src0_byp_rob_slot = rob[src0];
    assign src1_byp_rob_slot = rob[src1];

    // Lowest-numbered FU about to write back owns the writeback mux.
    always_comb begin
        wb_mux_sel = '0;
        for (int f = NUM_FU; f >= 1; f--) begin
            if (wb_lat[f][1]) wb_mux_sel = FW'(f);
        end
    end

    // Per-register tracking: non-spec issue beats spec issue beats squash beats aging/commit.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset) begin
                pending[r]   <= 1'b0;
                spec_mark[r] <= 1'b0;
                lat[r]       <= '0;
                fu[r]        <= '0;
            end else if (r != 0 && accept && dst == RW'(r)) begin
                pending[r]   <= 1'b1;
                spec_mark[r] <= 1'b0;
                lat[r]       <= latency;
                fu[r]        <= func_unit;
            end else if (r != 0 && spec_accept_Ihl && dst_spec == RW'(r)) begin
                pending[r]   <= 1'b1;
                spec_mark[r] <= 1'b1;
                lat[r]       <= latency_spec;
                fu[r]        <= func_unit_spec;
            end else if (spec_squash && spec_mark[r]) begin
                pending[r]   <= 1'b0;
                spec_mark[r] <= 1'b0;
                lat[r]       <= '0;
            end else begin
                lat[r] <= (lat[r] & stalls) | ((lat[r] & ~stalls) >> 1);
                if (rob_commit_wen && rob_commit_slot == rob[r]) pending[r] <= 1'b0;
                if (spec_resolve) spec_mark[r] <= 1'b0;
            end
        end
    end

    // ROB slot of the latest producer; left unreset since it is only meaningful while pending.
    always_ff @(posedge clk) begin
        for (int r = 1; r < NUM_REGS; r++) begin
            if (accept && dst == RW'(r))                       rob[r] <= rob_alloc_slot;
            else if (spec_accept_Ihl && dst_spec == RW'(r))    rob[r] <= rob_alloc_slot_spec;
        end
    end

    // Per-FU writeback occupancy; squash leaves it to drain conservatively.
    always_ff @(posedge clk) begin
        for (int f = 1; f <= NUM_FU; f++) begin
            if (reset) begin
                wb_lat[f] <= '0;
            end else begin
                wb_lat[f] <= (wb_lat[f] & stalls) | ((wb_lat[f] & ~stalls) >> 1)
                             | ((accept && func_unit == FW'(f)) ? latency : '0)
                             | ((spec_accept_Ihl && func_unit_spec == FW'(f)) ? latency_spec : '0);
            end
        end
    end

endmodule

// File: tb/tb_parc_core_scoreboard_multi.sv
// tb/tb_parc_core_scoreboard_multi.sv - scoreboard-style bench for parc_core_scoreboard_multi
module tb_parc_core_scoreboard_multi;

    localparam int RW = 5;
    localparam int FW = 2;
    localparam int LW = 6;
    localparam int OW = 4;
    localparam int SW = 3;

    localparam int K_SEL0 = 0, K_SEL1 = 1, K_ROB0 = 2, K_ROB1 = 3, K_STALL = 4, K_WB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] src0, src1, dst, dst_spec;
    logic          src0_en, src1_en, dst_en;
    logic [FW-1:0] func_unit, func_unit_spec;
    logic [LW-1:0] latency, latency_spec, stalls;
    logic          inst_val_Dhl, non_sb_stall_Dhl, spec_Dhl, spec_accept_Ihl;
    logic [OW-1:0] rob_alloc_slot, rob_alloc_slot_spec, rob_commit_slot;
    logic          rob_commit_wen, spec_resolve, spec_squash;
    logic [SW-1:0] src0_byp_mux_sel, src1_byp_mux_sel;
    logic [OW-1:0] src0_byp_rob_slot, src1_byp_rob_slot;
    logic          stall_hazard;
    logic [FW-1:0] wb_mux_sel;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    parc_core_scoreboard_multi dut (
        .clk(clk), .reset(reset),
        .src0(src0), .src0_en(src0_en), .src1(src1), .src1_en(src1_en),
        .dst(dst), .dst_en(dst_en), .func_unit(func_unit), .latency(latency),
        .inst_val_Dhl(inst_val_Dhl), .non_sb_stall_Dhl(non_sb_stall_Dhl), .spec_Dhl(spec_Dhl),
        .dst_spec(dst_spec), .func_unit_spec(func_unit_spec), .latency_spec(latency_spec),
        .spec_accept_Ihl(spec_accept_Ihl),
        .rob_alloc_slot(rob_alloc_slot), .rob_alloc_slot_spec(rob_alloc_slot_spec),
        .rob_commit_slot(rob_commit_slot), .rob_commit_wen(rob_commit_wen),
        .spec_resolve(spec_resolve), .spec_squash(spec_squash), .stalls(stalls),
        .src0_byp_mux_sel(src0_byp_mux_sel), .src1_byp_mux_sel(src1_byp_mux_sel),
        .src0_byp_rob_slot(src0_byp_rob_slot), .src1_byp_rob_slot(src1_byp_rob_slot),
        .stall_hazard(stall_hazard), .wb_mux_sel(wb_mux_sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_chk(input int kind, input int val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = 32'(val);
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        inst_val_Dhl = 0; non_sb_stall_Dhl = 0; spec_Dhl = 0;
        src0_en = 0; src1_en = 0; dst_en = 0; latency = '0; func_unit = '0;
        spec_accept_Ihl = 0; latency_spec = '0; func_unit_spec = '0; dst_spec = '0;
        rob_commit_wen = 0; spec_resolve = 0; spec_squash = 0; stalls = '0;
    endtask

    task automatic issue(input int d, input int f, input logic [LW-1:0] l, input int slot);
        inst_val_Dhl = 1; dst_en = 1; dst = RW'(d); func_unit = FW'(f);
        latency = l; rob_alloc_slot = OW'(slot);
    endtask

    task automatic rd0(input int s);
        inst_val_Dhl = 1; src0 = RW'(s); src0_en = 1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            tick();
        end
    endtask

    // Monitor: compares every queued expectation against the outputs mid-cycle.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_SEL0:  act = 32'(src0_byp_mux_sel);
                    K_SEL1:  act = 32'(src1_byp_mux_sel);
                    K_ROB0:  act = 32'(src0_byp_rob_slot);
                    K_ROB1:  act = 32'(src1_byp_rob_slot);
                    K_STALL: act = 32'(stall_hazard);
                    default: act = 32'(wb_mux_sel);
                endcase
                n_cmp++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1; src0 = '0; src1 = '0; dst = '0; rob_alloc_slot = '0;
        rob_alloc_slot_spec = '0; rob_commit_slot = '0;
        idle();
        tick();
        reset = 0;
        exp_chk(K_SEL0, 0, "reset_sel0"); exp_chk(K_SEL1, 0, "reset_sel1");
        exp_chk(K_WB, 0, "reset_wbsel"); exp_chk(K_STALL, 1, "reset_stall_noval");
        tick();

        // Idle source
        idle(); rd0(3);
        exp_chk(K_SEL0, 0, "idle_r3_sel"); exp_chk(K_STALL, 0, "idle_r3_stall");
        tick();

        // Accept r5, FU3, latency bit 3, slot A; follow it down the pipe
        idle(); issue(5, 3, 6'b001000, 10);
        exp_chk(K_STALL, 0, "acc_r5_stall");
        tick();
        idle(); rd0(5);
        exp_chk(K_STALL, 1, "r5_lat3_stall"); exp_chk(K_SEL0, 3, "r5_lat3_sel");
        tick();
        idle(); rd0(5);
        exp_chk(K_STALL, 1, "r5_lat2_stall"); exp_chk(K_SEL0, 3, "r5_lat2_sel");
        tick();
        idle(); rd0(5);
        exp_chk(K_STALL, 0, "r5_lat1b_stall"); exp_chk(K_SEL0, 3, "r5_lat1b_sel");
        exp_chk(K_WB, 3, "r5_wbsel");
        tick();
        idle(); rd0(5);
        exp_chk(K_SEL0, 4, "r5_wbstage_sel"); exp_chk(K_STALL, 0, "r5_wbstage_stall");
        tick();
        idle(); rd0(5); src1 = RW'(5); src1_en = 1;
        exp_chk(K_SEL0, 5, "r5_rob_sel0"); exp_chk(K_SEL1, 5, "r5_rob_sel1");
        exp_chk(K_ROB0, 10, "r5_rob_slot0"); exp_chk(K_ROB1, 10, "r5_rob_slot1");
        tick();

        // Writes to r0 are ignored
        idle(); issue(0, 1, 6'b000100, 7);
        tick();
        idle(); rd0(0);
        exp_chk(K_SEL0, 0, "r0_sel"); exp_chk(K_STALL, 0, "r0_stall");
        tick();
        idle_ticks(4);

        // Speculative issue to r7, same-cycle read conflict, then squash
        idle(); rd0(7);
        spec_accept_Ihl = 1; dst_spec = RW'(7); func_unit_spec = 2'd2;
        latency_spec = 6'b000100; rob_alloc_slot_spec = 4'd3;
        exp_chk(K_STALL, 1, "spec_conflict_stall");
        tick();
        idle(); rd0(7); spec_squash = 1;
        exp_chk(K_SEL0, 2, "spec_r7_sel"); exp_chk(K_STALL, 1, "spec_r7_stall");
        tick();
        idle(); rd0(7);
        exp_chk(K_SEL0, 0, "squash_r7_sel"); exp_chk(K_STALL, 0, "squash_r7_stall");
        tick();
        idle_ticks(4);

        // Writeback port conflict
        idle(); issue(10, 1, 6'b000100, 1);
        tick();
        idle(); issue(11, 2, 6'b000010, 8);
        exp_chk(K_STALL, 1, "wb_conflict_stall");
        tick();
        idle_ticks(4);
        idle(); issue(12, 1, 6'b000100, 2);
        tick();
        idle(); issue(13, 2, 6'b000100, 6);
        exp_chk(K_STALL, 0, "wb_noconflict_stall");
        tick();
        idle(); rd0(13);
        exp_chk(K_SEL0, 2, "r13_accepted_sel"); exp_chk(K_STALL, 1, "r13_accepted_stall");
        exp_chk(K_WB, 1, "r12_wbsel");
        tick();
        idle_ticks(4);

        // Commit clears pending
        idle(); issue(9, 1, 6'b000010, 9);
        tick();
        idle(); rd0(9); rob_commit_wen = 1; rob_commit_slot = 4'd9;
        exp_chk(K_SEL0, 1, "r9_pre_commit_sel"); exp_chk(K_STALL, 0, "r9_pre_commit_stall");
        tick();
        idle(); rd0(9);
        exp_chk(K_SEL0, 0, "r9_committed_sel");
        tick();

        // Commit of old slot together with a new accept to r9: new entry survives
        idle(); issue(9, 1, 6'b000100, 5);
        tick();
        idle(); issue(9, 2, 6'b001000, 12); rob_commit_wen = 1; rob_commit_slot = 4'd5;
        exp_chk(K_STALL, 0, "r9_reissue_stall");
        tick();
        idle(); rd0(9);
        exp_chk(K_SEL0, 2, "r9_reissue_sel"); exp_chk(K_STALL, 1, "r9_reissue_rdstall");
        tick();
        idle(); rd0(9); stalls = 6'b000100;
        exp_chk(K_SEL0, 2, "r9_lat2_sel");
        tick();
        idle(); rd0(9);
        exp_chk(K_STALL, 1, "r9_held_stall");
        tick();
        idle(); rd0(9);
        exp_chk(K_STALL, 0, "r9_lat1b_stall");
        tick();
        idle(); rd0(9);
        exp_chk(K_SEL0, 4, "r9_wbstage_sel");
        tick();
        idle(); rd0(9); rob_commit_wen = 1; rob_commit_slot = 4'd12;
        exp_chk(K_SEL0, 5, "r9_rob_sel"); exp_chk(K_ROB0, 12, "r9_rob_slot");
        tick();
        idle(); rd0(9);
        exp_chk(K_SEL0, 0, "r9_final_sel");
        tick();

        idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
